// File: rtl/imuldiv_div_arbiter.sv
// rtl/imuldiv_div_arbiter.sv - round-robin arbiter sharing one iterative divider between two ports
// At most one request is outstanding; the response is routed back to the issuing port.
module imuldiv_div_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_msg_fn,
  input  logic [31:0] req0_msg_a,
  input  logic [31:0] req0_msg_b,
  input  logic        req0_val,
  output logic        req0_rdy,
  input  logic        req1_msg_fn,
  input  logic [31:0] req1_msg_a,
  input  logic [31:0] req1_msg_b,
  input  logic        req1_val,
  output logic        req1_rdy,
  output logic [63:0] resp0_msg_result,
  output logic        resp0_val,
  input  logic        resp0_rdy,
  output logic [63:0] resp1_msg_result,
  output logic        resp1_val,
  input  logic        resp1_rdy,
  output logic        divreq_msg_fn,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  output logic        divreq_val,
  input  logic        divreq_rdy,
  input  logic [63:0] divresp_msg_result,
  input  logic        divresp_val,
  output logic        divresp_rdy,
  output logic        busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_owner;
  logic   w_owner_next;
  logic   r_prio;
  logic   w_prio_next;
  logic   w_any_val;
  logic   w_winner;
  logic   w_req_fire;
  logic   w_resp_fire;

  // With a single requester its own index wins; with none, port 0 is selected.
  assign w_any_val = req0_val | req1_val;
  assign w_winner  = (req0_val & req1_val) ? r_prio : req1_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_prio  <= w_prio_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_owner_next  = r_owner;
    w_prio_next   = r_prio;
    req0_rdy      = 1'b0;
    req1_rdy      = 1'b0;
    resp0_val     = 1'b0;
    resp1_val     = 1'b0;
    divreq_val    = 1'b0;
    divresp_rdy   = 1'b0;
    divreq_msg_fn = req0_msg_fn;
    divreq_msg_a  = req0_msg_a;
    divreq_msg_b  = req0_msg_b;
    w_req_fire    = 1'b0;
    w_resp_fire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_winner) begin
          divreq_msg_fn = req1_msg_fn;
          divreq_msg_a  = req1_msg_a;
          divreq_msg_b  = req1_msg_b;
        end
        divreq_val = w_any_val;
        req0_rdy   = w_any_val & ~w_winner & divreq_rdy;
        req1_rdy   = w_any_val & w_winner & divreq_rdy;
        w_req_fire = w_any_val & divreq_rdy;
        if (w_req_fire) begin
          w_state_next = ST_BUSY;
          w_owner_next = w_winner;
          w_prio_next  = ~w_winner;
        end
      end
      ST_BUSY: begin
        resp0_val   = divresp_val & ~r_owner;
        resp1_val   = divresp_val & r_owner;
        divresp_rdy = r_owner ? resp1_rdy : resp0_rdy;
        w_resp_fire = divresp_val & divresp_rdy;
        if (w_resp_fire) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    // Handshakes are suppressed for the whole reset cycle, not just after the edge.
    if (reset) begin
      req0_rdy    = 1'b0;
      req1_rdy    = 1'b0;
      resp0_val   = 1'b0;
      resp1_val   = 1'b0;
      divreq_val  = 1'b0;
      divresp_rdy = 1'b0;
    end
  end

  assign resp0_msg_result = divresp_msg_result;
  assign resp1_msg_result = divresp_msg_result;
  assign busy             = (r_state == ST_BUSY) & ~reset;

endmodule

// File: tb/tb_imuldiv_div_arbiter.sv
// tb/tb_imuldiv_div_arbiter.sv - self-checking bench for the two-port divider arbiter
// Plays both requesters and the iterative divider; a transaction-level model predicts grants and results.
module tb_imuldiv_div_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rq_fn      [2];
  logic [31:0] rq_a       [2];
  logic [31:0] rq_b       [2];
  logic        rq_val     [2];
  logic        o_req_rdy  [2];
  logic [63:0] o_resp_res [2];
  logic        o_resp_val [2];
  logic        rs_rdy     [2];
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a;
  logic [31:0] divreq_msg_b;
  logic        divreq_val;
  logic        divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val;
  logic        divresp_rdy;
  logic        busy;

  always #5 clk = ~clk;

  imuldiv_div_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_msg_fn(rq_fn[0]), .req0_msg_a(rq_a[0]), .req0_msg_b(rq_b[0]),
    .req0_val(rq_val[0]), .req0_rdy(o_req_rdy[0]),
    .req1_msg_fn(rq_fn[1]), .req1_msg_a(rq_a[1]), .req1_msg_b(rq_b[1]),
    .req1_val(rq_val[1]), .req1_rdy(o_req_rdy[1]),
    .resp0_msg_result(o_resp_res[0]), .resp0_val(o_resp_val[0]), .resp0_rdy(rs_rdy[0]),
    .resp1_msg_result(o_resp_res[1]), .resp1_val(o_resp_val[1]), .resp1_rdy(rs_rdy[1]),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
    .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
    .divresp_rdy(divresp_rdy), .busy(busy)
  );

  typedef struct {
    logic        fn;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  typedef struct {
    int          port;
    logic        fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  req_t        pq0 [$];
  req_t        pq1 [$];
  logic        en_val [2];
  logic        en_rdy [2];
  int          total, bad, cyc;
  logic        ref_busy, ref_owner, ref_prio, seen_val;
  logic [63:0] ref_exp;
  int          t_fire;
  int          grants [$];
  int          done_total, last_port, last_done_cyc;
  int          done_port [2];
  logic [63:0] last_res;
  int          dv_state, dv_cnt;
  logic [63:0] dv_res;

  function automatic logic [63:0] ref_div(input logic fn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (fn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int p, input logic fn, input logic [31:0] a, input logic [31:0] b);
    req_t r;
    r.fn = fn;
    r.a  = a;
    r.b  = b;
    if (p == 0) pq0.push_back(r);
    else        pq1.push_back(r);
  endtask

  task automatic drive();
    rq_val[0] = en_val[0] && (pq0.size() > 0);
    rq_val[1] = en_val[1] && (pq1.size() > 0);
    if (pq0.size() > 0) begin
      rq_fn[0] = pq0[0].fn; rq_a[0] = pq0[0].a; rq_b[0] = pq0[0].b;
    end
    if (pq1.size() > 0) begin
      rq_fn[1] = pq1[0].fn; rq_a[1] = pq1[0].a; rq_b[1] = pq1[0].b;
    end
    rs_rdy[0] = en_rdy[0];
    rs_rdy[1] = en_rdy[1];
  endtask

  task automatic step();
    logic        rst_s, any, w, rf0, rf1, pf0, pf1, dqf, dpf, ref_req, ref_resp;
    logic        dq_fn;
    logic [31:0] dq_a, dq_b;
    logic [63:0] pr0, pr1;
    req_t        tmp;
    drive();
    @(negedge clk);
    rst_s    = reset;
    any      = rq_val[0] | rq_val[1];
    w        = (rq_val[0] && rq_val[1]) ? ref_prio : rq_val[1];
    ref_req  = 1'b0;
    ref_resp = 1'b0;
    if (rst_s) begin
      chk("rst req0_rdy", o_req_rdy[0], 0);
      chk("rst req1_rdy", o_req_rdy[1], 0);
      chk("rst resp0_val", o_resp_val[0], 0);
      chk("rst resp1_val", o_resp_val[1], 0);
      chk("rst divreq_val", divreq_val, 0);
      chk("rst divresp_rdy", divresp_rdy, 0);
      chk("rst busy", busy, 0);
    end else if (!ref_busy) begin
      chk("idle busy", busy, 0);
      chk("idle divreq_val", divreq_val, any);
      chk("idle resp0_val", o_resp_val[0], 0);
      chk("idle resp1_val", o_resp_val[1], 0);
      chk("idle divresp_rdy", divresp_rdy, 0);
      chk("grant req0_rdy", o_req_rdy[0], any && !w && divreq_rdy);
      chk("grant req1_rdy", o_req_rdy[1], any && w && divreq_rdy);
      if (any) begin
        chk("route fn", divreq_msg_fn, rq_fn[w]);
        chk("route a", divreq_msg_a, rq_a[w]);
        chk("route b", divreq_msg_b, rq_b[w]);
      end
      ref_req = any && divreq_rdy;
    end else begin
      chk("busy busy", busy, 1);
      chk("busy divreq_val", divreq_val, 0);
      chk("busy req0_rdy", o_req_rdy[0], 0);
      chk("busy req1_rdy", o_req_rdy[1], 0);
      chk("owner resp_val", o_resp_val[ref_owner], divresp_val);
      chk("other resp_val", o_resp_val[!ref_owner], 0);
      chk("divresp_rdy", divresp_rdy, rs_rdy[ref_owner]);
      if (divresp_val) begin
        chk("owner result", o_resp_res[ref_owner], ref_exp);
        if (!seen_val) begin
          chk("latency", 64'(cyc - t_fire), 64'd33);
          seen_val = 1'b1;
        end
      end
      ref_resp = divresp_val && rs_rdy[ref_owner];
    end
    rf0   = rq_val[0] && o_req_rdy[0];
    rf1   = rq_val[1] && o_req_rdy[1];
    pf0   = o_resp_val[0] && rs_rdy[0];
    pf1   = o_resp_val[1] && rs_rdy[1];
    pr0   = o_resp_res[0];
    pr1   = o_resp_res[1];
    dqf   = divreq_val && divreq_rdy;
    dpf   = divresp_val && divresp_rdy;
    dq_fn = divreq_msg_fn;
    dq_a  = divreq_msg_a;
    dq_b  = divreq_msg_b;
    @(posedge clk);
    cyc++;
    #1;
    if (rf0) tmp = pq0.pop_front();
    if (rf1) tmp = pq1.pop_front();
    if (pf0) begin
      last_res = pr0; last_port = 0; done_total++; done_port[0]++; last_done_cyc = cyc - 1;
    end
    if (pf1) begin
      last_res = pr1; last_port = 1; done_total++; done_port[1]++; last_done_cyc = cyc - 1;
    end
    if (rst_s) begin
      ref_busy  = 1'b0;
      ref_owner = 1'b0;
      ref_prio  = 1'b0;
      dv_state  = 0;
    end else begin
      if (ref_req) begin
        ref_busy  = 1'b1;
        ref_owner = w;
        ref_prio  = !w;
        ref_exp   = ref_div(rq_fn[w], rq_a[w], rq_b[w]);
        t_fire    = cyc - 1;
        seen_val  = 1'b0;
        grants.push_back(int'(w));
      end
      if (ref_resp) ref_busy = 1'b0;
      if (dv_state == 0 && dqf) begin
        dv_res   = ref_div(dq_fn, dq_a, dq_b);
        dv_state = 1;
        dv_cnt   = 32;
      end else if (dv_state == 1) begin
        dv_cnt--;
        if (dv_cnt == 0) dv_state = 2;
      end else if (dv_state == 2 && dpf) begin
        dv_state = 0;
      end
    end
    divreq_rdy         = (dv_state == 0);
    divresp_val        = (dv_state == 2);
    divresp_msg_result = dv_res;
    #1;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_total < n && k < budget) begin
      step();
      k++;
    end
    chk("response timeout", 64'(done_total >= n), 64'd1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    vec_t vt [6];
    int   n, k, p, pushed, start;
    logic [63:0] held;
    logic [31:0] ra, rb;
    logic        rfn;

    total = 0; bad = 0; cyc = 0;
    done_total = 0; done_port[0] = 0; done_port[1] = 0; last_port = -1; last_res = '0;
    ref_busy = 0; ref_owner = 0; ref_prio = 0; seen_val = 0; ref_exp = '0; t_fire = 0;
    dv_state = 0; dv_cnt = 0; dv_res = '0;
    divreq_rdy = 1'b1; divresp_val = 1'b0; divresp_msg_result = '0;
    for (int i = 0; i < 2; i++) begin
      en_val[i] = 1'b1; en_rdy[i] = 1'b1;
      rq_fn[i] = 1'b0; rq_a[i] = '0; rq_b[i] = 32'd1; rq_val[i] = 1'b0; rs_rdy[i] = 1'b1;
    end
    reset = 1'b1;

    vt[0] = '{0, 1'b0, 32'd100,        32'd7,         64'h00000002_0000000E};
    vt[1] = '{1, 1'b1, 32'hFFFFFFF9,   32'd2,         64'hFFFFFFFF_FFFFFFFD};
    vt[2] = '{0, 1'b1, 32'd100,        32'hFFFFFFF9,  64'h00000002_FFFFFFF2};
    vt[3] = '{1, 1'b0, 32'hFFFFFFFF,   32'd16,        64'h0000000F_0FFFFFFF};
    vt[4] = '{0, 1'b1, 32'h80000000,   32'd2,         64'h00000000_C0000000};
    vt[5] = '{1, 1'b0, 32'd5,          32'd9,         64'h00000005_00000000};

    do_reset(3);

    for (int i = 0; i < 6; i++) begin
      n = done_total;
      push(vt[i].port, vt[i].fn, vt[i].a, vt[i].b);
      wait_done(n + 1, 200);
      chk("vec port", 64'(last_port), 64'(vt[i].port));
      chk("vec result", last_res, vt[i].exp);
    end

    // Simultaneous requests straight out of reset: port 0 first, then port 1 one cycle after.
    do_reset(2);
    grants.delete();
    n = done_total;
    push(0, 1'b0, 32'd20, 32'd3);
    push(1, 1'b0, 32'd9, 32'd4);
    wait_done(n + 1, 200);
    chk("tie first port", 64'(last_port), 64'd0);
    chk("tie first result", last_res, 64'h00000002_00000006);
    k = last_done_cyc;
    wait_done(n + 2, 200);
    chk("tie second port", 64'(last_port), 64'd1);
    chk("tie second result", last_res, 64'h00000001_00000002);
    chk("back-to-back spacing", 64'(last_done_cyc - k), 64'd34);
    push(0, 1'b0, 32'd1, 32'd1);
    push(1, 1'b0, 32'd2, 32'd1);
    wait_done(n + 4, 400);
    chk("tie grant count", 64'(grants.size()), 64'd4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk("tie grant order", 64'(grants[i]), 64'(i % 2));

    // Response backpressure while port 1 waits.
    n = done_total;
    en_rdy[0] = 1'b0;
    push(0, 1'b0, 32'd1000, 32'd3);
    push(1, 1'b0, 32'd50, 32'd5);
    k = 0;
    while (!o_resp_val[0] && k < 100) begin
      step();
      k++;
    end
    chk("bp resp0_val rose", 64'(o_resp_val[0]), 64'd1);
    held = o_resp_res[0];
    chk("bp held result", held, 64'h00000001_0000014D);
    repeat (10) begin
      step();
      chk("bp result stable", o_resp_res[0], held);
      chk("bp req1_rdy", 64'(o_req_rdy[1]), 64'd0);
    end
    chk("bp no fire", 64'(done_total), 64'(n));
    en_rdy[0] = 1'b1;
    step();
    chk("bp fire on first rdy", 64'(done_total), 64'(n + 1));
    wait_done(n + 2, 200);
    chk("bp port1 result", last_res, 64'h00000000_0000000A);

    // Reset ten cycles into a port 0 transaction; port 1 holds val through reset.
    push(0, 1'b0, 32'd77, 32'd5);
    k = 0;
    while (!busy && k < 50) begin
      step();
      k++;
    end
    chk("mid busy", 64'(busy), 64'd1);
    repeat (10) step();
    n = done_port[0];
    p = done_total;
    reset = 1'b1;
    push(1, 1'b0, 32'd8, 32'd2);
    repeat (3) step();
    reset = 1'b0;
    wait_done(p + 1, 200);
    chk("mid port0 dropped", 64'(done_port[0]), 64'(n));
    chk("mid port1 port", 64'(last_port), 64'd1);
    chk("mid port1 result", last_res, 64'h00000000_00000004);

    // Fairness: both ports continuously valid for six transactions.
    do_reset(2);
    grants.delete();
    n = done_total;
    for (int i = 0; i < 3; i++) begin
      push(0, 1'($urandom_range(0, 1)), $urandom, 32'($urandom_range(1, 1000)));
      push(1, 1'($urandom_range(0, 1)), $urandom, 32'($urandom_range(1, 1000)));
    end
    wait_done(n + 6, 600);
    chk("fair grant count", 64'(grants.size()), 64'd6);
    for (int i = 0; i < grants.size() && i < 6; i++)
      chk("fair grant order", 64'(grants[i]), 64'(i % 2));

    // Randomized traffic with ragged val and response backpressure.
    start  = done_total;
    pushed = 0;
    for (int i = 0; i < 4000; i++) begin
      if (pushed < 100 && $urandom_range(0, 3) == 0) begin
        p   = $urandom_range(0, 1);
        rfn = 1'($urandom_range(0, 1));
        ra  = $urandom;
        rb  = $urandom;
        if ($urandom_range(0, 1) == 0) rb = 32'($urandom_range(1, 300));
        if (rb == 32'd0) rb = 32'd3;
        if (rfn && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
        if ((p == 0 ? pq0.size() : pq1.size()) < 3) begin
          push(p, rfn, ra, rb);
          pushed++;
        end
      end
      en_val[0] = ($urandom_range(0, 3) != 0);
      en_val[1] = ($urandom_range(0, 3) != 0);
      en_rdy[0] = ($urandom_range(0, 3) != 0);
      en_rdy[1] = ($urandom_range(0, 3) != 0);
      step();
    end
    en_val[0] = 1'b1; en_val[1] = 1'b1;
    en_rdy[0] = 1'b1; en_rdy[1] = 1'b1;
    wait_done(start + pushed, 20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imuldiv_div_arbiter.md
# imuldiv_div_arbiter

Two-port arbiter that shares one iterative integer divide unit between two requesters, for example the X-stage divide path and a debug/test port. It accepts val/rdy divide requests on two input ports and keeps at most one request outstanding at the divider. It uses round-robin priority and routes each 64-bit result back to the port that issued the request. It sits between the requesters and the divider, and connects to the divider's divreq/divresp signals without any adapter.

## Interface
- Parameters: none (two ports, 32-bit operands, 64-bit result are fixed).
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req0_msg_fn / req1_msg_fn  input  1  1 = signed divide, 0 = unsigned.
- req0_msg_a / req1_msg_a  input  32  dividend.
- req0_msg_b / req1_msg_b  input  32  divisor.
- req0_val / req1_val  input  1  request valid.
- req0_rdy / req1_rdy  output  1  request ready.
- resp0_msg_result / resp1_msg_result  output  64  {remainder[63:32], quotient[31:0]}.
- resp0_val / resp1_val  output  1  response valid.
- resp0_rdy / resp1_rdy  input  1  response ready.
- divreq_msg_fn, divreq_msg_a, divreq_msg_b  output  1/32/32  operands to the divider.
- divreq_val  output  1 / divreq_rdy  input  1  divider request handshake.
- divresp_msg_result  input  64 / divresp_val  input  1 / divresp_rdy  output  1  divider response handshake.
- busy  output  1  high while a request is outstanding (state BUSY).

## Operation
- **State registers**
  - state: IDLE or BUSY.
  - owner: 1 bit, the port that issued the outstanding request.
  - prio: 1 bit, the port that wins a tie.
- **IDLE**
  - Winner selection:
    - Only one reqN_val high: that port wins.
    - Both high: port prio wins.
    - Neither high: no winner.
  - divreq_val = winner's val. divreq_msg_* = winner's fields, or port 0's fields when there is no winner.
  - Winner's reqN_rdy = divreq_rdy. The loser's rdy = 0.
  - Request fire = divreq_val && divreq_rdy. On fire:
    - owner <= winner.
    - prio <= ~winner.
    - state <= BUSY.
  - resp0_val = resp1_val = 0 and divresp_rdy = 0.
- **BUSY**
  - divreq_val = 0, req0_rdy = req1_rdy = 0.
  - resp[owner]_val = divresp_val and resp[owner]_msg_result = divresp_msg_result.
  - The non-owner port has resp_val = 0, and its result is driven to the same data; consumers must qualify it with val.
  - divresp_rdy = resp[owner]_rdy.
  - Response fire = divresp_val && divresp_rdy. On fire, state <= IDLE; prio is unchanged.
- No new request is issued in the same cycle as a response fire. The divider cannot accept one then anyway: it returns to WAIT on the following edge.
- The arbiter does no arithmetic. Operands and results pass through unmodified; sign handling belongs to the divider.
- Fairness: a port that holds val continuously is granted within at most one other transaction.

## Timing
- **Reset**
  - state = IDLE, owner = 0, prio = 0.
  - While reset is high, all val/rdy outputs are forced to 0 (req*_rdy, resp*_val, divreq_val, divresp_rdy) and busy = 0.
- **Handshake paths**
  - Request path is combinational: reqN_val to divreq_val, and divreq_rdy to reqN_rdy.
  - Response path is combinational: divresp_val to respN_val, and respN_rdy to divresp_rdy.
  - Requesters must not make val depend on rdy.
- **Latency**
  - Arbiter adds zero cycles to request or response.
  - End-to-end latency with the iterative divider: request accepted in cycle T (divider in WAIT); result valid at resp[owner]_val from cycle T+33 (32 CALC cycles, then DONE).
  - The result is held until resp[owner]_rdy is high.
- **Back-to-back**: response fire at cycle R gives state IDLE at R+1; the next request can fire at R+1.
- **Boundary conditions**
  - Response backpressure (resp[owner]_rdy low): remain in BUSY indefinitely. Other port's requests stay un-acked (rdy = 0).
  - Requester drops val in IDLE before fire: no grant, no state change.
  - Reset asserted in BUSY: the arbiter returns to IDLE and any outstanding response is discarded. The divider shares this reset.
  - divresp_val high while IDLE is illegal. It is ignored, since divresp_rdy = 0.

## Test plan
- **Single unsigned request**: port0 sends fn=0, a=100, b=7, accepted at T -> resp0_val at T+33 with result 0x00000002_0000000E. resp1_val stays 0; busy is high from T+1 until response fire.
- **Signed request on port 1**: fn=1, a=-7 (0xFFFFFFF9), b=2 -> resp1 result 0xFFFFFFFF_FFFFFFFD (rem -1, quo -3). owner = 1, and prio = 0 afterward.
- **Simultaneous requests from reset**: both val held, with port0 (a=20, b=3) and port1 (a=9, b=4) -> port0 granted first with result 0x00000002_00000006. port1 is granted the cycle after port0's response fire, with result 0x00000001_00000002. The next tie goes to port0.
- **Response backpressure**: hold resp0_rdy=0 for 10 cycles after resp0_val rises -> result is stable, divresp_rdy=0, and req1_rdy=0 throughout. Fire occurs on the first cycle resp0_rdy=1.
- **Reset mid-operation**: assert reset 10 cycles after a port0 grant -> after reset, all val/rdy outputs are 0 and busy=0, and no response is ever delivered. A new port1 request with a=8, b=2 returns 0x00000000_00000004.
- **Fairness stress**: both ports continuously valid for 6 transactions -> grants strictly alternate 0,1,0,1,0,1, and each result matches a reference model.
